// File: rtl/game_io_pkg.sv
// Port map and ctrl bit positions for the KCPSM6 game I/O hub.
package game_io_pkg;

  localparam logic [7:0] P_BTNS  = 8'h00;
  localparam logic [7:0] P_SW    = 8'h01;
  localparam logic [7:0] P_LED   = 8'h02;
  localparam logic [7:0] P_DIG0  = 8'h03;
  localparam logic [7:0] P_DP    = 8'h07;
  localparam logic [7:0] P_GINFO = 8'h09;
  localparam logic [7:0] P_IMASK = 8'h0A;
  localparam logic [7:0] P_IPEND = 8'h0B;
  localparam logic [7:0] P_CTRL  = 8'h0C;
  localparam logic [7:0] P_RAND  = 8'h0F;

  localparam int CTRL_TICK_EN = 0;

endpackage

// File: rtl/game_io_hub_irq_ctrl.sv
// Edge-detected event sources plus a periodic tick, sticky pending bits,
// mask and an ack/re-arm interrupt handshake.
module irq_ctrl
  import game_io_pkg::*;
#(
  parameter int N_IRQ       = 2,
  parameter int TICK_PERIOD = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_src,
  input  logic             tick_en,
  input  logic             mask_we,
  input  logic             pend_we,
  input  logic [N_IRQ:0]   wdata,
  input  logic             interrupt_ack,
  output logic [N_IRQ:0]   irq_mask,
  output logic [N_IRQ:0]   pend,
  output logic             interrupt
);

  localparam int CW = $clog2(TICK_PERIOD);
  localparam logic [CW-1:0] TC = CW'(TICK_PERIOD - 1);

  logic [CW-1:0]    cnt;
  logic             tick;
  logic             armed;
  logic [N_IRQ-1:0] src_q;
  logic [N_IRQ:0]   ev;
  logic [N_IRQ:0]   w1c;

  assign tick = tick_en && (cnt == TC);
  assign ev   = {tick, irq_src & ~src_q};
  assign w1c  = pend_we ? wdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      src_q     <= '0;
      irq_mask  <= '0;
      pend      <= '0;
      armed     <= 1'b1;
      interrupt <= 1'b0;
    end else begin
      src_q <= irq_src;
      if (!tick_en || tick)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (mask_we)
        irq_mask <= wdata;
      // an event landing on a bit being cleared still sets it
      pend <= (pend & ~w1c) | ev;
      if (interrupt_ack) begin
        interrupt <= 1'b0;
        armed     <= 1'b0;
      end else begin
        if (armed && |(pend & irq_mask))
          interrupt <= 1'b1;
        if (pend_we)
          armed <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_io_hub.sv
// Port-mapped register file between kcpsm6 and the game datapath:
// output registers, registered read mux and the interrupt block.
module game_io_hub
  import game_io_pkg::*;
#(
  parameter int TICK_PERIOD = 50_000_000,
  parameter int N_IRQ       = 2,
  parameter int N_DIG       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         port_id,
  input  logic [7:0]         out_port,
  input  logic               write_strobe,
  input  logic               k_write_strobe,
  input  logic               read_strobe,
  output logic [7:0]         in_port,
  output logic               interrupt,
  input  logic               interrupt_ack,
  input  logic [3:0]         db_btns,
  input  logic [7:0]         db_sw,
  input  logic [1:0]         randomized_value,
  input  logic [N_IRQ-1:0]   irq_src,
  output logic [7:0]         led,
  output logic [5*N_DIG-1:0] dig,
  output logic [N_DIG-1:0]   dp,
  output logic [7:0]         game_info
);

  logic           ctrl;
  logic [7:0]     rd;
  logic [N_IRQ:0] irq_mask;
  logic [N_IRQ:0] pend;
  logic           unused_ok;

  // OUTPUTK and read_strobe carry no behaviour here
  assign unused_ok = ^{k_write_strobe, read_strobe};

  irq_ctrl #(
    .N_IRQ       (N_IRQ),
    .TICK_PERIOD (TICK_PERIOD)
  ) u_irq (
    .clk           (clk),
    .rst           (rst),
    .irq_src       (irq_src),
    .tick_en       (ctrl),
    .mask_we       (write_strobe && port_id == P_IMASK),
    .pend_we       (write_strobe && port_id == P_IPEND),
    .wdata         (out_port[N_IRQ:0]),
    .interrupt_ack (interrupt_ack),
    .irq_mask      (irq_mask),
    .pend          (pend),
    .interrupt     (interrupt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led       <= '0;
      dig       <= '0;
      dp        <= '0;
      game_info <= '0;
      ctrl      <= 1'b0;
    end else if (write_strobe) begin
      if (port_id == P_LED)   led       <= out_port;
      if (port_id == P_DP)    dp        <= out_port[N_DIG-1:0];
      if (port_id == P_GINFO) game_info <= out_port;
      if (port_id == P_CTRL)  ctrl      <= out_port[CTRL_TICK_EN];
      for (int k = 0; k < N_DIG; k++)
        if (port_id == 8'(P_DIG0 + k))
          dig[5*k +: 5] <= out_port[4:0];
    end
  end

  always_comb begin
    rd = '0;
    case (port_id)
      P_BTNS:  rd = {4'b0, db_btns};
      P_SW:    rd = db_sw;
      P_LED:   rd[N_IRQ-1:0] = irq_src;
      P_GINFO: rd = game_info;
      P_IMASK: rd[N_IRQ:0] = irq_mask;
      P_IPEND: rd[N_IRQ:0] = pend;
      P_CTRL:  rd[CTRL_TICK_EN] = ctrl;
      P_RAND:  rd = {6'b0, randomized_value};
      default: rd = '0;
    endcase
    for (int k = 0; k < N_DIG; k++)
      if (port_id == 8'(P_DIG0 + k))
        rd = {3'b0, dig[5*k +: 5]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_port <= '0;
    else     in_port <= rd;
  end

endmodule

// File: tb/tb_game_io_hub.sv
// Directed plus randomized checks of game_io_hub against a cycle-level
// model built from the register map and interrupt rules.
module tb_game_io_hub;

  localparam int T  = 10;
  localparam int NI = 2;
  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    port_id, out_port;
  logic          write_strobe, k_write_strobe, read_strobe;
  logic [7:0]    in_port;
  logic          interrupt, interrupt_ack;
  logic [3:0]    db_btns;
  logic [7:0]    db_sw;
  logic [1:0]    randomized_value;
  logic [NI-1:0] irq_src;
  logic [7:0]    led;
  logic [5*ND-1:0] dig;
  logic [ND-1:0] dp;
  logic [7:0]    game_info;

  game_io_hub #(.TICK_PERIOD(T), .N_IRQ(NI), .N_DIG(ND)) dut (
    .clk(clk), .rst(rst), .port_id(port_id), .out_port(out_port),
    .write_strobe(write_strobe), .k_write_strobe(k_write_strobe),
    .read_strobe(read_strobe), .in_port(in_port),
    .interrupt(interrupt), .interrupt_ack(interrupt_ack),
    .db_btns(db_btns), .db_sw(db_sw),
    .randomized_value(randomized_value), .irq_src(irq_src),
    .led(led), .dig(dig), .dp(dp), .game_info(game_info)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0]    m_led, m_gi, m_in;
  logic [4:0]    m_dig [ND];
  logic [ND-1:0] m_dp;
  logic          m_ctrl, m_int, m_armed;
  logic [NI:0]   m_mask, m_pend;
  logic [NI-1:0] m_src;
  int            m_age;

  task automatic model_reset();
    m_led = '0; m_gi = '0; m_in = '0; m_dp = '0;
    for (int k = 0; k < ND; k++) m_dig[k] = '0;
    m_ctrl = 0; m_int = 0; m_armed = 1;
    m_mask = '0; m_pend = '0; m_src = '0; m_age = 0;
  endtask

  function automatic logic [7:0] m_read(logic [7:0] a);
    case (a)
      8'h00: return {4'b0, db_btns};
      8'h01: return db_sw;
      8'h02: return 8'(irq_src);
      8'h03, 8'h04, 8'h05, 8'h06: return 8'(m_dig[int'(a) - 3]);
      8'h09: return m_gi;
      8'h0A: return 8'(m_mask);
      8'h0B: return 8'(m_pend);
      8'h0C: return {7'b0, m_ctrl};
      8'h0F: return {6'b0, randomized_value};
      default: return 8'h00;
    endcase
  endfunction

  task automatic compare();
    logic [5*ND-1:0] pd;
    for (int k = 0; k < ND; k++) pd[5*k +: 5] = m_dig[k];
    chk("led", led, m_led);
    chk("dig", dig, pd);
    chk("dp", dp, m_dp);
    chk("game_info", game_info, m_gi);
    chk("in_port", in_port, m_in);
    chk("interrupt", interrupt, m_int);
  endtask

  task automatic step();
    logic        tick, int_n, armed_n, ctrl_n, wpend;
    logic [NI:0] ev, w1c, pend_n, mask_n;
    logic [7:0]  in_n, led_n, gi_n;
    logic [ND-1:0] dp_n;
    logic [4:0]  dig_n [ND];
    int          age_n;
    age_n = m_ctrl ? m_age + 1 : 0;
    tick  = m_ctrl && (age_n % T == 0);
    ev    = {tick, irq_src & ~m_src};
    wpend = write_strobe && port_id == 8'h0B;
    w1c   = wpend ? out_port[NI:0] : '0;
    pend_n = (m_pend & ~w1c) | ev;
    if (interrupt_ack) begin
      int_n = 0; armed_n = 0;
    end else begin
      int_n   = m_int | (m_armed && |(m_pend & m_mask));
      armed_n = m_armed | wpend;
    end
    in_n = m_read(port_id);
    led_n = m_led; gi_n = m_gi; dp_n = m_dp;
    ctrl_n = m_ctrl; mask_n = m_mask;
    for (int k = 0; k < ND; k++) dig_n[k] = m_dig[k];
    if (write_strobe) begin
      case (port_id)
        8'h02: led_n = out_port;
        8'h03, 8'h04, 8'h05, 8'h06:
          dig_n[int'(port_id) - 3] = out_port[4:0];
        8'h07: dp_n = out_port[ND-1:0];
        8'h09: gi_n = out_port;
        8'h0A: mask_n = out_port[NI:0];
        8'h0C: ctrl_n = out_port[0];
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    m_age = age_n; m_src = irq_src; m_pend = pend_n;
    m_int = int_n; m_armed = armed_n; m_in = in_n;
    m_led = led_n; m_gi = gi_n; m_dp = dp_n;
    m_ctrl = ctrl_n; m_mask = mask_n;
    for (int k = 0; k < ND; k++) m_dig[k] = dig_n[k];
    compare();
  endtask

  task automatic wr(logic [7:0] a, logic [7:0] d);
    port_id = a; out_port = d; write_strobe = 1;
    step();
    write_strobe = 0;
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic ack();
    interrupt_ack = 1;
    step();
    interrupt_ack = 0;
  endtask

  task automatic tick_latency(string tag);
    int n;
    wr(8'h0A, 8'h04);
    wr(8'h0C, 8'h01);
    n = 0;
    while (!interrupt && n < 40) begin
      step();
      n++;
    end
    chk(tag, 32'(n), 32'(T + 1));
    ack();
    wr(8'h0C, 8'h00);
    wr(8'h0A, 8'h00);
    wr(8'h0B, 8'h07);
  endtask

  logic [7:0] pool [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                           8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B,
                           8'h0C, 8'h0F, 8'h20, 8'h0D};

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; port_id = 0; out_port = 0; write_strobe = 0;
    k_write_strobe = 0; read_strobe = 0; interrupt_ack = 0;
    db_btns = 0; db_sw = 0; randomized_value = 0; irq_src = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_led", led, 0);
    chk("rst_in_port", in_port, 0);
    chk("rst_irq", interrupt, 0);
    chk("rst_dig", dig, 0);

    wr(8'h02, 8'h55);
    wr(8'h03, 8'h1F);
    wr(8'h07, 8'h03);
    chk("led_55", led, 8'h55);
    chk("dig0_1f", dig[4:0], 5'h1F);
    chk("dp_3", dp, 4'b0011);
    wr(8'h20, 8'hFF);
    chk("unmapped_led", led, 8'h55);
    chk("unmapped_dig", dig, 20'h0001F);
    chk("unmapped_gi", game_info, 8'h00);

    db_sw = 8'hA5; port_id = 8'h01;
    step();
    chk("rd_sw", in_port, 8'hA5);
    port_id = 8'h30;
    step();
    chk("rd_unmapped", in_port, 8'h00);

    tick_latency("tick_lat");

    wr(8'h0A, 8'h01);
    irq_src = 2'b01;
    idle(20);
    port_id = 8'h0B;
    step();
    chk("held_pend", in_port, 8'h01);
    chk("held_irq", interrupt, 1);
    ack();
    chk("ack_clr", interrupt, 0);
    wr(8'h0B, 8'h01);
    step();
    chk("w1c_pend", in_port, 8'h00);
    chk("w1c_noirq", interrupt, 0);
    irq_src = 2'b00;
    step();

    wr(8'h0A, 8'h05);
    ack();
    wr(8'h0C, 8'h01);
    idle(T - 1);
    irq_src = 2'b01;
    step();
    wr(8'h0C, 8'h00);
    port_id = 8'h0B;
    step();
    chk("both_pend", in_port, 8'h05);
    chk("disarmed", interrupt, 0);
    wr(8'h0B, 8'h01);
    chk("irq_at_w1c", interrupt, 0);
    step();
    chk("irq_rearm", interrupt, 1);
    chk("pend_after_w1c", in_port, 8'h04);
    ack();
    wr(8'h0B, 8'h07);

    irq_src = 2'b00;
    step();
    irq_src = 2'b01;
    step();
    irq_src = 2'b00;
    step();
    irq_src = 2'b01;
    wr(8'h0B, 8'h01);
    step();
    chk("set_wins", in_port[0], 1);
    ack();
    wr(8'h0B, 8'h07);
    wr(8'h0A, 8'h00);
    irq_src = 2'b00;
    step();

    wr(8'h02, 8'hAA);
    wr(8'h09, 8'h3C);
    wr(8'h0C, 8'h01);
    idle(3);
    #3 rst = 1;
    #1;
    chk("arst_led", led, 0);
    chk("arst_dig", dig, 0);
    chk("arst_dp", dp, 0);
    chk("arst_gi", game_info, 0);
    chk("arst_in", in_port, 0);
    chk("arst_irq", interrupt, 0);
    model_reset();
    #1 rst = 0;
    tick_latency("tick_after_rst");

    repeat (1500) begin
      db_btns = 4'($urandom);
      db_sw = 8'($urandom);
      randomized_value = 2'($urandom);
      k_write_strobe = 1'($urandom);
      read_strobe = 1'($urandom);
      if ($urandom_range(0, 3) == 0) irq_src = NI'($urandom);
      interrupt_ack = ($urandom_range(0, 7) == 0);
      write_strobe = ($urandom_range(0, 2) == 0);
      port_id = pool[$urandom_range(0, 15)];
      out_port = 8'($urandom);
      step();
    end
    write_strobe = 0;
    interrupt_ack = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
